// File: rtl/wb_sram_pkg.sv
// -----------------------------------------------------------------------------
// wb_sram_pkg
// Shared definitions for the Wishbone-to-SRAM-macro bridge.
//   sram_state_e : bridge FSM states (IDLE, ACCESS, RD_WAIT)
//   MAX_RD_LAT   : largest macro read latency the bridge can wait for
// -----------------------------------------------------------------------------
package wb_sram_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    RD_WAIT = 2'd2
  } sram_state_e;

  localparam int MAX_RD_LAT = 4;

endpackage : wb_sram_pkg

// File: rtl/wb_sram_bridge.sv
// -----------------------------------------------------------------------------
// wb_sram_bridge
// Wishbone classic slave that terminates the S0 (SRAM) port of the
// interconnect and drives a single-port OpenRAM-style macro.
//
// Ports
//   clk_i, rst_i           : clock, synchronous active-high reset
//   wb_cyc_i/wb_stb_i      : bus cycle / strobe from S0
//   wb_we_i                : 1 = write, 0 = read
//   wb_sel_i [DATA_W/8]    : byte selects (writes only)
//   wb_adr_i [ADDR_W]      : word address
//   wb_dat_i [DATA_W]      : write data
//   wb_dat_o [DATA_W]      : read data, registered, holds last read value
//   wb_ack_o               : one-cycle ack pulse, registered
//   sram_csb_o/sram_web_o  : macro chip select / write enable, active low
//   sram_wmask_o           : macro byte write mask
//   sram_addr_o/sram_din_o : macro address / write data
//   sram_dout_i            : macro read data, valid READ_LATENCY cycles
//                            after the capture edge
//
// Every output comes straight from a flop; there is no combinational path
// from the Wishbone inputs to any output.
// -----------------------------------------------------------------------------
module wb_sram_bridge
  import wb_sram_pkg::*;
#(
  parameter int ADDR_W       = 8,
  parameter int DATA_W       = 32,
  parameter int READ_LATENCY = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  wb_cyc_i,
  input  logic                  wb_stb_i,
  input  logic                  wb_we_i,
  input  logic [DATA_W/8-1:0]   wb_sel_i,
  input  logic [ADDR_W-1:0]     wb_adr_i,
  input  logic [DATA_W-1:0]     wb_dat_i,
  output logic [DATA_W-1:0]     wb_dat_o,
  output logic                  wb_ack_o,
  output logic                  sram_csb_o,
  output logic                  sram_web_o,
  output logic [DATA_W/8-1:0]   sram_wmask_o,
  output logic [ADDR_W-1:0]     sram_addr_o,
  output logic [DATA_W-1:0]     sram_din_o,
  input  logic [DATA_W-1:0]     sram_dout_i
);

  localparam int SEL_W = DATA_W / 8;
  localparam int CNT_W = $clog2(MAX_RD_LAT);

  // The counter counts down to zero, so it is loaded with one less than the
  // number of cycles between the capture edge and valid dout.
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(READ_LATENCY - 1);

  if ((READ_LATENCY < 1) || (READ_LATENCY > MAX_RD_LAT)) begin : g_bad_read_latency
    $error("wb_sram_bridge: READ_LATENCY must be within 1..%0d", MAX_RD_LAT);
  end

  sram_state_e        state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ack_q, ack_d;
  logic [DATA_W-1:0]  dat_q, dat_d;
  logic               csb_q, csb_d;
  logic               web_q, web_d;
  logic [SEL_W-1:0]   wmask_q, wmask_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [DATA_W-1:0]  din_q, din_d;

  logic start;

  // The ~ack_q term stops an S0 master that still shows stb during the ack
  // cycle from launching a second access for the same request.
  assign start = wb_cyc_i & wb_stb_i & ~ack_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ack_d   = 1'b0;
    dat_d   = dat_q;
    csb_d   = 1'b1;     // chip select is a single-cycle pulse by default
    web_d   = 1'b1;
    wmask_d = wmask_q;
    addr_d  = addr_q;
    din_d   = din_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          csb_d   = 1'b0;
          web_d   = ~wb_we_i;
          addr_d  = wb_adr_i;
          din_d   = wb_dat_i;
          wmask_d = wb_we_i ? wb_sel_i : '0;
          state_d = ACCESS;
        end
      end

      ACCESS: begin
        // The macro captures at the end of this cycle whatever happens, so a
        // write that is aborted here still lands in the array.
        if (!wb_cyc_i) begin
          state_d = IDLE;
        end else if (!web_q) begin
          ack_d   = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d   = CNT_LOAD;
          state_d = RD_WAIT;
        end
      end

      RD_WAIT: begin
        if (!wb_cyc_i) begin
          state_d = IDLE;
        end else if (cnt_q == '0) begin
          dat_d   = sram_dout_i;
          ack_d   = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ack_q   <= 1'b0;
      dat_q   <= '0;
      csb_q   <= 1'b1;
      web_q   <= 1'b1;
      wmask_q <= '0;
      addr_q  <= '0;
      din_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ack_q   <= ack_d;
      dat_q   <= dat_d;
      csb_q   <= csb_d;
      web_q   <= web_d;
      wmask_q <= wmask_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
    end
  end

  assign wb_dat_o     = dat_q;
  assign wb_ack_o     = ack_q;
  assign sram_csb_o   = csb_q;
  assign sram_web_o   = web_q;
  assign sram_wmask_o = wmask_q;
  assign sram_addr_o  = addr_q;
  assign sram_din_o   = din_q;

endmodule : wb_sram_bridge
